// File: rtl/alert_scheduler.sv
// ============================================================================
// alert_scheduler
// Arbitrates threat-sensor sources onto a single green/yellow/red pulse line.
// Optional: define ALERT_SCHED_LOCK_EN to lock out stimulus on FAIL/EXPANSION.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alert_scheduler #(
    parameter int N_SRC       = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     req,
    input  logic [2*N_SRC-1:0]   color,
    input  logic [3:0]           llm_state,
    output logic                 green,
    output logic                 red,
    output logic                 yellow,
    output logic [N_SRC-1:0]     grant,
    output logic                 busy,
    output logic                 locked
);

    localparam int         c_PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [5:0] c_HOLD  = 6'(HOLD_CYCLES);
    localparam logic [5:0] c_GAP   = 6'(GAP_CYCLES);
    localparam logic [1:0] c_GREEN = 2'b01;
    localparam logic [1:0] c_YEL   = 2'b10;
    localparam logic [1:0] c_RED   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_GAP    = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t               r_state, w_state;
    logic [c_PTR_W-1:0]   r_ptr,   w_ptr;
    logic [5:0]           r_cnt,   w_cnt;
    logic [1:0]           r_col,   w_col;
    logic [N_SRC-1:0]     r_grant, w_grant;

    logic [N_SRC-1:0]     w_red_v, w_yel_v, w_grn_v;
    logic [c_PTR_W:0]     w_red_pick, w_yel_pick, w_grn_pick;
    logic                 w_sel_found;
    logic [c_PTR_W-1:0]   w_sel_idx;
    logic [1:0]           w_sel_col;

    // Returns {found, index} of the first set bit at or after p, wrapping.
    function automatic logic [c_PTR_W:0] rr_pick(input logic [N_SRC-1:0] v,
                                                 input logic [c_PTR_W-1:0] p);
        logic [c_PTR_W:0] res;
        int               j;
        res = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            j = (int'(p) + k) % N_SRC;
            if (v[c_PTR_W'(j)]) res = {1'b1, c_PTR_W'(j)};
        end
        return res;
    endfunction

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(N_SRC - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        w_red_v = '0;
        w_yel_v = '0;
        w_grn_v = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_red_v[i] = req[i] && (color[2*i +: 2] == c_RED);
            w_yel_v[i] = req[i] && (color[2*i +: 2] == c_YEL);
            w_grn_v[i] = req[i] && (color[2*i +: 2] == c_GREEN);
        end
    end

    assign w_red_pick = rr_pick(w_red_v, r_ptr);
    assign w_yel_pick = rr_pick(w_yel_v, r_ptr);
    assign w_grn_pick = rr_pick(w_grn_v, r_ptr);

    always_comb begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_grn_pick[c_PTR_W-1:0];
        w_sel_col   = c_GREEN;
        if (w_red_pick[c_PTR_W]) begin
            w_sel_idx = w_red_pick[c_PTR_W-1:0];
            w_sel_col = c_RED;
        end else if (w_yel_pick[c_PTR_W]) begin
            w_sel_idx = w_yel_pick[c_PTR_W-1:0];
            w_sel_col = c_YEL;
        end else if (!w_grn_pick[c_PTR_W]) begin
            w_sel_found = 1'b0;
        end
    end

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_cnt   = r_cnt;
        w_col   = r_col;
        w_grant = '0;
        case (r_state)
            S_IDLE: begin
                w_col = 2'b00;
                if (w_sel_found) begin
                    w_state            = S_HOLD;
                    w_cnt              = 6'd1;
                    w_col              = w_sel_col;
                    w_grant[w_sel_idx] = 1'b1;
                    w_ptr              = ptr_inc(w_sel_idx);
                end
            end
            S_HOLD: begin
                // Red preemption outranks the normal end of a pulse.
                if (r_col != c_RED && w_red_pick[c_PTR_W]) begin
                    w_cnt                              = 6'd1;
                    w_col                              = c_RED;
                    w_grant[w_red_pick[c_PTR_W-1:0]]   = 1'b1;
                    w_ptr                              = ptr_inc(w_red_pick[c_PTR_W-1:0]);
                end else if (r_cnt == c_HOLD) begin
                    w_col = 2'b00;
                    if (GAP_CYCLES > 0) begin
                        w_state = S_GAP;
                        w_cnt   = 6'd1;
                    end else begin
                        w_state = S_IDLE;
                        w_cnt   = 6'd0;
                    end
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end
            S_GAP: begin
                w_col = 2'b00;
                if (r_cnt == c_GAP) begin
                    w_state = S_IDLE;
                    w_cnt   = 6'd0;
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end
            default: begin
                w_col = 2'b00;
                w_cnt = 6'd0;
            end
        endcase
`ifdef ALERT_SCHED_LOCK_EN
        if (llm_state == 4'b0100 || llm_state == 4'b0101) begin
            w_state = S_LOCKED;
            w_col   = 2'b00;
            w_cnt   = 6'd0;
            w_grant = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= 6'd0;
            r_col   <= 2'b00;
            r_grant <= '0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_col   <= w_col;
            r_grant <= w_grant;
        end
    end

    assign green  = (r_col == c_GREEN);
    assign yellow = (r_col == c_YEL);
    assign red    = (r_col == c_RED);
    assign grant  = r_grant;
    assign busy   = (r_state == S_HOLD) || (r_state == S_GAP);

`ifdef ALERT_SCHED_LOCK_EN
    assign locked = (r_state == S_LOCKED);
`else
    logic w_unused_llm_state;
    assign w_unused_llm_state = ^llm_state;
    assign locked = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alert_scheduler.sv
// ============================================================================
// tb_alert_scheduler
// Directed + randomized bench with a pulse-level reference model and grant scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alert_scheduler;

    localparam int N    = 4;
    localparam int HOLD = 3;
    localparam int GAP  = 1;
`ifdef ALERT_SCHED_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [2*N-1:0] color;
    logic [3:0]     llm_state;
    wire            green, red, yellow, busy, locked;
    wire  [N-1:0]   grant;
    logic [N-1:0]   sticky;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        int cls;
    } gexp_t;
    gexp_t exp_q[$];

    // Model: remaining pulse cycles, remaining quiet (busy) cycles, colour class.
    int m_pulse, m_quiet, m_col, m_ptr;
    bit m_locked;

    alert_scheduler #(.N_SRC(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset(reset), .req(req), .color(color),
        .llm_state(llm_state), .green(green), .red(red), .yellow(yellow),
        .grant(grant), .busy(busy), .locked(locked)
    );

    always #5 clock = ~clock;

    function automatic int find_src(int cls);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req[j] && int'(color[2*j +: 2]) == cls) return j;
        end
        return -1;
    endfunction

    function automatic void model_grant(int w, int cls);
        gexp_t e;
        m_pulse = HOLD;
        m_col   = cls;
        m_ptr   = (w + 1) % N;
        e.idx   = w;
        e.cls   = cls;
        exp_q.push_back(e);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pulse = 0; m_quiet = 0; m_col = 0; m_ptr = 0; m_locked = 1'b0;
            exp_q.delete();
        end else if (m_locked) begin
            m_col = 0;
        end else if (LOCK_EN && (llm_state == 4'd4 || llm_state == 4'd5)) begin
            m_locked = 1'b1; m_pulse = 0; m_quiet = 0; m_col = 0;
        end else if (m_pulse > 0) begin
            int r;
            r = find_src(3);
            if (m_col != 3 && r >= 0) begin
                model_grant(r, 3);
            end else begin
                m_pulse--;
                if (m_pulse == 0) begin
                    m_col   = 0;
                    m_quiet = GAP;
                end
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else begin
            for (int cls = 3; cls >= 1; cls--) begin
                int w;
                w = find_src(cls);
                if (w >= 0) begin
                    model_grant(w, cls);
                    break;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [4:0] got, want;
        int act_cls;
        got  = {green, yellow, red, busy, locked};
        want = {m_col == 1, m_col == 2, m_col == 3,
                (m_pulse > 0) || (m_quiet > 0), m_locked};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL outputs t=%0t {g,y,r,busy,locked} got=%b expected=%b", $time, got, want);
        end
        act_cls = red ? 3 : (yellow ? 2 : (green ? 1 : 0));
        if (grant != '0 || exp_q.size() > 0) begin
            checks++;
            if (grant == '0) begin
                gexp_t e;
                e = exp_q.pop_front();
                errors++;
                $display("FAIL grant_missing t=%0t got=%b expected src=%0d cls=%0d", $time, grant, e.idx, e.cls);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected t=%0t got=%b expected none", $time, grant);
            end else begin
                gexp_t e;
                e = exp_q.pop_front();
                if (grant != N'(1 << e.idx) || act_cls != e.cls) begin
                    errors++;
                    $display("FAIL grant t=%0t got=%b cls=%0d expected src=%0d cls=%0d",
                             $time, grant, act_cls, e.idx, e.cls);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
        for (int i = 0; i < N; i++)
            if (grant[i] && !sticky[i]) req[i] = 1'b0;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic set_src(int i, logic [1:0] c);
        req[i] = 1'b1;
        color[2*i +: 2] = c;
    endtask

    task automatic do_reset();
        req = '0; sticky = '0; llm_state = 4'd0;
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; color = '0; llm_state = 4'd0; sticky = '0;
        #2;
        checks++;
        if ({green, yellow, red, busy, locked, grant} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b expected=0", {green, yellow, red, busy, locked, grant});
        end
        ticks(2);
        reset = 1'b0;

        // Single green request from source 2.
        set_src(2, 2'b01);
        ticks(8);
        // Green vs yellow at the same edge: yellow wins.
        set_src(0, 2'b01);
        set_src(3, 2'b10);
        ticks(12);
        // Two sticky green sources alternate.
        sticky[1:0] = 2'b11;
        set_src(0, 2'b01);
        set_src(1, 2'b01);
        ticks(20);
        sticky = '0;
        req = '0;
        ticks(6);
        // Red preempts a green pulse in its second cycle.
        set_src(1, 2'b01);
        ticks(2);
        set_src(2, 2'b11);
        ticks(10);

        // Randomized traffic.
        for (int t = 0; t < 500; t++) begin
            int v;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        color[2*i +: 2] = 2'($urandom_range(0, 3));
                        sticky[i] = ($urandom_range(0, 7) == 0);
                    end
                end else if (color[2*i +: 2] == 2'b00 && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b0;
                end else if (sticky[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                    sticky[i] = 1'b0;
                end
            end
            v = $urandom_range(0, 15);
            if (v == 4 || v == 5) v = 0;
            llm_state = 4'(v);
        end
        sticky = '0; req = '0; llm_state = 4'd0;
        ticks(8);

        // Lock mid-pulse, then further requests.
        set_src(1, 2'b01);
        ticks(2);
        llm_state = 4'b0100;
        tick();
        llm_state = 4'd0;
        set_src(0, 2'b11);
        set_src(3, 2'b10);
        ticks(12);
        do_reset();
        ticks(2);

        // Asynchronous reset mid-HOLD.
        set_src(3, 2'b10);
        ticks(2);
        @(posedge clock);
        #2;
        reset = 1'b1;
        req = '0;
        #1;
        checks++;
        if ({green, yellow, red, busy, grant} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b expected=0", {green, yellow, red, busy, grant});
        end
        tick();
        reset = 1'b0;
        set_src(1, 2'b01);
        set_src(3, 2'b01);
        ticks(14);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
